// File: rtl/lailai_bist_seq.sv
// BIST sequencer for the cell y = ~a & (~(b&c) | d).
// Walks all 16 vectors, compares against GOLDEN, reports results.
module lailai_bist_seq #(
    parameter logic [15:0] GOLDEN = 16'h00BF,
    parameter int          DWELL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       dut_d,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(DWELL - 1);

    state_t     state;
    state_t     nxt;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic [4:0] err_q;
    logic [3:0] ffv_q;
    logic       ffok_q;
    logic       go;
    logic       miss;
    logic       active;

    // abort beats start; start only counts when parked
    assign go   = (state == IDLE || state == DONE) && start && !abort;
    assign miss = (dut_y != GOLDEN[vec]);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next-state decode
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (go) nxt = DRIVE;
            end
            DRIVE: begin
                if (abort)             nxt = IDLE;
                else if (cnt == LAST)  nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort)             nxt = IDLE;
                else if (vec == 4'hF)  nxt = DONE;
                else                   nxt = DRIVE;
            end
            DONE: begin
                if (abort)             nxt = IDLE;
                else if (go)           nxt = DRIVE;
            end
            default: nxt = IDLE;
        endcase
    end

    // vector index, dwell counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec    <= 4'd0;
            cnt    <= 4'd0;
            err_q  <= 5'd0;
            ffv_q  <= 4'd0;
            ffok_q <= 1'b0;
        end else if (go) begin
            vec    <= 4'd0;
            cnt    <= 4'd0;
            err_q  <= 5'd0;
            ffv_q  <= 4'd0;
            ffok_q <= 1'b0;
        end else if (state == DRIVE && !abort) begin
            if (cnt != LAST) cnt <= cnt + 4'd1;
        end else if (state == SAMPLE && !abort) begin
            if (miss) begin
                err_q <= err_q + 5'd1;
                if (!ffok_q) begin
                    ffv_q  <= vec;
                    ffok_q <= 1'b1;
                end
            end
            if (vec != 4'hF) begin
                vec <= vec + 4'd1;
                cnt <= 4'd0;
            end
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        active           = (state == DRIVE) || (state == SAMPLE);
        busy             = active;
        done             = (state == DONE);
        pass             = (state == DONE) && (err_q == 5'd0);
        dut_a            = active & vec[3];
        dut_b            = active & vec[2];
        dut_c            = active & vec[1];
        dut_d            = active & vec[0];
        err_cnt          = err_q;
        first_fail_vec   = ffv_q;
        first_fail_valid = ffok_q;
    end

endmodule

// File: tb/tb_lailai_bist_seq.sv
// Scoreboard bench for lailai_bist_seq.
// Two instances: DWELL=1 (a) and DWELL=3 (b).
module tb_lailai_bist_seq;

    typedef struct {
        int lat;
        int err;
        int ffok;
        int ffv;
        int pas;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];

    // instance a signals
    logic       sa = 1'b0, aa = 1'b0;
    logic       a_a, a_b, a_c, a_d, a_y;
    logic       a_busy, a_done, a_pass, a_ffok;
    logic [4:0] a_err;
    logic [3:0] a_ffv;
    int         mode = 0;

    // instance b signals
    logic       sb = 1'b0, ab = 1'b0;
    logic       b_a, b_b, b_c, b_d, b_y;
    logic       b_busy, b_done, b_pass, b_ffok;
    logic [4:0] b_err;
    logic [3:0] b_ffv;

    lailai_bist_seq #(.GOLDEN(16'h00BF), .DWELL(1)) ua (
        .clk(clk), .rst(rst), .start(sa), .abort(aa),
        .dut_a(a_a), .dut_b(a_b), .dut_c(a_c), .dut_d(a_d),
        .dut_y(a_y), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_cnt(a_err), .first_fail_vec(a_ffv),
        .first_fail_valid(a_ffok)
    );

    lailai_bist_seq #(.GOLDEN(16'h00BF), .DWELL(3)) ub (
        .clk(clk), .rst(rst), .start(sb), .abort(ab),
        .dut_a(b_a), .dut_b(b_b), .dut_c(b_c), .dut_d(b_d),
        .dut_y(b_y), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err), .first_fail_vec(b_ffv),
        .first_fail_valid(b_ffok)
    );

    // cell model: 0 good, 1 stuck-at-0, 2 wrong only at vector 6
    logic a_good;
    assign a_good = ~a_a & (~(a_b & a_c) | a_d);
    assign a_y = (mode == 1) ? 1'b0 :
                 (mode == 2 && {a_a, a_b, a_c, a_d} == 4'd6) ? 1'b1 :
                 a_good;
    assign b_y = ~b_a & (~(b_b & b_c) | b_d);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // monitor a: vector order every busy cycle, results on done rise
    int  ia = 0;
    logic pba = 1'b0, pda = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_busy) begin
                if (!pba) ia = 0;
                chk("a_vec", int'({a_a, a_b, a_c, a_d}), ia / 2);
                ia++;
            end
            if (a_done && !pda) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_lat", ia, e.lat);
                    chk("a_err", int'(a_err), e.err);
                    chk("a_ffok", int'(a_ffok), e.ffok);
                    if (e.ffok != 0) chk("a_ffv", int'(a_ffv), e.ffv);
                    chk("a_pass", int'(a_pass), e.pas);
                    chk("a_dut_idle", int'({a_a, a_b, a_c, a_d}), 0);
                end
            end
        end
        pba = a_busy;
        pda = a_done;
    end

    // monitor b
    int  ib = 0;
    logic pbb = 1'b0, pdb = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (b_busy) begin
                if (!pbb) ib = 0;
                chk("b_vec", int'({b_a, b_b, b_c, b_d}), ib / 4);
                ib++;
            end
            if (b_done && !pdb) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_lat", ib, e.lat);
                    chk("b_err", int'(b_err), e.err);
                    chk("b_ffok", int'(b_ffok), e.ffok);
                    chk("b_pass", int'(b_pass), e.pas);
                end
            end
        end
        pbb = b_busy;
        pdb = b_done;
    end

    task automatic start_a();
        @(negedge clk) sa = 1'b1;
        @(posedge clk) #1 sa = 1'b0;
        chk("a_busy_next", int'(a_busy), 1);
        chk("a_done_clr", int'(a_done), 0);
    endtask

    task automatic wait_a();
        for (int i = 0; i < 200 && !a_done; i++) @(negedge clk);
        chk("a_done_timeout", int'(a_done), 1);
        @(negedge clk);
    endtask

    task automatic push_a(input int lat, input int err,
                          input int ffok, input int ffv, input int pas);
        exp_t e;
        e.lat = lat; e.err = err; e.ffok = ffok; e.ffv = ffv; e.pas = pas;
        qa.push_back(e);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);
        chk("rst_pass", int'(a_pass), 0);
        chk("rst_err", int'(a_err), 0);
        chk("rst_ffok", int'(a_ffok), 0);
        chk("rst_ffv", int'(a_ffv), 0);
        chk("rst_dut", int'({a_a, a_b, a_c, a_d}), 0);

        // 1: fault-free
        mode = 0;
        push_a(32, 0, 0, 0, 1);
        start_a();
        wait_a();

        // 2: stuck-at-0 cell misses vectors 0-5 and 7
        mode = 1;
        push_a(32, 7, 1, 0, 0);
        start_a();
        wait_a();

        // 3: single fault at vector 6
        mode = 2;
        push_a(32, 1, 1, 6, 0);
        start_a();
        wait_a();

        // 4: DWELL=3 instance
        e.lat = 64; e.err = 0; e.ffok = 0; e.ffv = 0; e.pas = 1;
        qb.push_back(e);
        @(negedge clk) sb = 1'b1;
        @(posedge clk) #1 sb = 1'b0;
        chk("b_busy_next", int'(b_busy), 1);
        for (int i = 0; i < 300 && !b_done; i++) @(negedge clk);
        chk("b_done_timeout", int'(b_done), 1);
        @(negedge clk);

        // 5a: abort at edge 10 of a stuck-at-0 run; 4 samples done
        mode = 1;
        start_a();
        repeat (9) @(posedge clk);
        @(negedge clk) aa = 1'b1;
        @(posedge clk) #1;
        chk("ab_busy", int'(a_busy), 0);
        chk("ab_done", int'(a_done), 0);
        chk("ab_dut", int'({a_a, a_b, a_c, a_d}), 0);
        chk("ab_err_kept", int'(a_err), 4);
        chk("ab_ffok_kept", int'(a_ffok), 1);
        aa = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("ab_idle", int'(a_busy), 0);

        // 5b: full run after abort
        mode = 0;
        push_a(32, 0, 0, 0, 1);
        start_a();
        wait_a();

        // 5c: start re-pulsed mid-run is ignored
        push_a(32, 0, 0, 0, 1);
        start_a();
        repeat (10) @(posedge clk);
        @(negedge clk) sa = 1'b1;
        @(posedge clk) #1 sa = 1'b0;
        wait_a();

        // 6: async reset mid-run
        mode = 1;
        start_a();
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_busy", int'(a_busy), 0);
        chk("ar_done", int'(a_done), 0);
        chk("ar_err", int'(a_err), 0);
        chk("ar_ffok", int'(a_ffok), 0);
        chk("ar_dut", int'({a_a, a_b, a_c, a_d}), 0);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ar_quiet_busy", int'(a_busy), 0);
        chk("ar_quiet_done", int'(a_done), 0);
        chk("ar_quiet_dut", int'({a_a, a_b, a_c, a_d}), 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
